// File: rtl/timer_service_master_if.sv
// Avalon-MM bus between timer_service_master and the 16-bit interval-timer slave.
interface timer_service_master_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_service_master.sv
// Programs and services the interval-timer slave and emits one frame tick per timeout.
// Counter snapshot readback is built only when TIMER_SERVICE_SNAPSHOT_EN is defined.
//
// state    | meaning
// IDLE     | timer not owned, bus idle
// WR_P0..3 | write period halfwords (addr 2..5)
// WR_RUN   | write START|CONT|ITO control word
// RUN      | timer running, waiting for stop / irq / snapshot request
// CLR      | clear timeout status, tick pulse
// WAIT1    | idle cycle so the slave irq can fall
// WR_STOP  | write STOP control word
// SNAP_WR  | write snapshot register to latch the counter
// SNAP_RD0 | read snapshot low
// SNAP_RD1 | read snapshot high, capture low
// SNAP_CAP | capture high, snap_valid
module timer_service_master #(
  parameter logic [15:0] CTRL_RUN_WORD  = 16'h0007,
  parameter logic [15:0] CTRL_STOP_WORD = 16'h0008
) (
  input  logic                   clk,
  input  logic                   reset_n,
  timer_service_master_if.master bus,
  input  logic [31:0]            cfg_period,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  output logic                   busy,
  output logic                   tick,
  output logic [15:0]            tick_count,
  input  logic                   snap_req,
  output logic [31:0]            snap_value,
  output logic                   snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_RUN, RUN, CLR, WAIT1, WR_STOP
`ifdef TIMER_SERVICE_SNAPSHOT_EN
    , SNAP_WR, SNAP_RD0, SNAP_RD1, SNAP_CAP
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] period_q, period_nxt;
  logic        stop_pending, stop_pending_nxt;
  logic [3:0]  addr_nxt;
  logic        cs_nxt;
  logic        wn_nxt;
  logic [15:0] wd_nxt;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
  logic snap_pending, snap_pending_nxt;
`endif

  always_comb begin
    state_nxt        = state;
    period_nxt       = period_q;
    stop_pending_nxt = stop_pending;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          period_nxt = cfg_period;
          state_nxt  = WR_P0;
        end
      end
      WR_P0:  state_nxt = WR_P1;
      WR_P1:  state_nxt = WR_P2;
      WR_P2:  state_nxt = WR_P3;
      WR_P3:  state_nxt = WR_RUN;
      WR_RUN: state_nxt = RUN;
      RUN: begin
        if (stop_pending || cfg_stop)
          state_nxt = WR_STOP;
        else if (bus.irq)
          state_nxt = CLR;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
        else if (snap_pending || snap_req)
          state_nxt = SNAP_WR;
`endif
      end
      CLR:     state_nxt = WAIT1;
      WAIT1:   state_nxt = RUN;
      WR_STOP: state_nxt = IDLE;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
      SNAP_WR:  state_nxt = SNAP_RD0;
      SNAP_RD0: state_nxt = SNAP_RD1;
      SNAP_RD1: state_nxt = SNAP_CAP;
      SNAP_CAP: state_nxt = RUN;
`endif
      default: state_nxt = IDLE;
    endcase

    if (state == WR_STOP)
      stop_pending_nxt = 1'b0;
    else if (cfg_stop && state != IDLE && state != RUN)
      stop_pending_nxt = 1'b1;
  end

`ifdef TIMER_SERVICE_SNAPSHOT_EN
  always_comb begin
    snap_pending_nxt = snap_pending;
    if (state == IDLE || state_nxt == SNAP_WR)
      snap_pending_nxt = 1'b0;
    else if (snap_req)
      snap_pending_nxt = 1'b1;
  end
`endif

  // Bus outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    addr_nxt = 4'd0;
    cs_nxt   = 1'b0;
    wn_nxt   = 1'b1;
    wd_nxt   = 16'h0000;
    case (state_nxt)
      WR_P0:   begin addr_nxt = 4'd2; cs_nxt = 1'b1; wn_nxt = 1'b0; wd_nxt = period_nxt[15:0];  end
      WR_P1:   begin addr_nxt = 4'd3; cs_nxt = 1'b1; wn_nxt = 1'b0; wd_nxt = period_nxt[31:16]; end
      WR_P2:   begin addr_nxt = 4'd4; cs_nxt = 1'b1; wn_nxt = 1'b0; end
      WR_P3:   begin addr_nxt = 4'd5; cs_nxt = 1'b1; wn_nxt = 1'b0; end
      WR_RUN:  begin addr_nxt = 4'd1; cs_nxt = 1'b1; wn_nxt = 1'b0; wd_nxt = CTRL_RUN_WORD;  end
      CLR:     begin addr_nxt = 4'd0; cs_nxt = 1'b1; wn_nxt = 1'b0; end
      WR_STOP: begin addr_nxt = 4'd1; cs_nxt = 1'b1; wn_nxt = 1'b0; wd_nxt = CTRL_STOP_WORD; end
`ifdef TIMER_SERVICE_SNAPSHOT_EN
      SNAP_WR:  begin addr_nxt = 4'd6; cs_nxt = 1'b1; wn_nxt = 1'b0; end
      SNAP_RD0: begin addr_nxt = 4'd6; cs_nxt = 1'b1; end
      SNAP_RD1: begin addr_nxt = 4'd7; cs_nxt = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      period_q       <= '0;
      stop_pending   <= 1'b0;
      bus.address    <= 4'd0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.writedata  <= 16'h0000;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= 16'h0000;
    end else begin
      state          <= state_nxt;
      period_q       <= period_nxt;
      stop_pending   <= stop_pending_nxt;
      bus.address    <= addr_nxt;
      bus.chipselect <= cs_nxt;
      bus.write_n    <= wn_nxt;
      bus.writedata  <= wd_nxt;
      busy           <= (state_nxt != IDLE);
      tick           <= (state_nxt == CLR);
      if (state_nxt == CLR)
        tick_count <= tick_count + 16'd1;
    end
  end

`ifdef TIMER_SERVICE_SNAPSHOT_EN
  // readdata lags the address by one cycle, so each half is captured one state late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pending <= 1'b0;
      snap_value   <= '0;
      snap_valid   <= 1'b0;
    end else begin
      snap_pending <= snap_pending_nxt;
      snap_valid   <= (state == SNAP_CAP);
      if (state == SNAP_RD1)
        snap_value[15:0] <= bus.readdata;
      if (state == SNAP_CAP)
        snap_value[31:16] <= bus.readdata;
    end
  end
`else
  logic [16:0] unused_snap;
  assign unused_snap = {snap_req, bus.readdata};
  assign snap_value  = '0;
  assign snap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_service_master.sv
// Directed plus randomized bench for timer_service_master with a transaction-level timer slave model.
module tb_timer_service_master;

  logic        clk;
  logic        reset_n;
  logic [31:0] cfg_period;
  logic        cfg_start;
  logic        cfg_stop;
  logic        busy;
  logic        tick;
  logic [15:0] tick_count;
  logic        snap_req;
  logic [31:0] snap_value;
  logic        snap_valid;

  timer_service_master_if bus_if ();

  timer_service_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if.master),
    .cfg_period (cfg_period),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .busy       (busy),
    .tick       (tick),
    .tick_count (tick_count),
    .snap_req   (snap_req),
    .snap_value (snap_value),
    .snap_valid (snap_valid)
  );

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_count;
  logic [31:0] model_snap;
  logic [31:0] slave_counter;
  logic [31:0] slave_latched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer slave: snapshot register latches the counter on a write, reads have latency 1.
  always @(posedge clk) begin
    if (bus_if.chipselect && !bus_if.write_n && bus_if.address == 4'd6)
      slave_latched <= slave_counter;
    if (bus_if.chipselect && bus_if.write_n)
      case (bus_if.address)
        4'd6:    bus_if.readdata <= slave_latched[15:0];
        4'd7:    bus_if.readdata <= slave_latched[31:16];
        default: bus_if.readdata <= 16'h0000;
      endcase
    else
      bus_if.readdata <= 16'h0000;
  end

  function automatic logic [21:0] wr(input logic [3:0] a, input logic [15:0] d);
    return {1'b1, 1'b0, a, d};
  endfunction

  function automatic logic [21:0] rd(input logic [3:0] a);
    return {1'b1, 1'b1, a, 16'h0000};
  endfunction

  localparam logic [21:0] IDLE_BUS = {1'b0, 1'b1, 4'd0, 16'h0000};

  function automatic logic [21:0] bus_now();
    return {bus_if.chipselect, bus_if.write_n, bus_if.address, bus_if.writedata};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string tag, input logic [31:0] p, input int stop_at, input int restart_at);
    logic [21:0] exp_w [5];
    exp_w[0] = wr(4'd2, p[15:0]);
    exp_w[1] = wr(4'd3, p[31:16]);
    exp_w[2] = wr(4'd4, 16'h0000);
    exp_w[3] = wr(4'd5, 16'h0000);
    exp_w[4] = wr(4'd1, 16'h0007);
    cfg_period = p;
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_bus"}, 64'(bus_now()), 64'(exp_w[i]));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (i == stop_at) cfg_stop = 1'b1;
      if (i == restart_at) begin
        cfg_start  = 1'b1;
        cfg_period = $urandom;
      end
      step();
      cfg_stop  = 1'b0;
      cfg_start = 1'b0;
    end
    chk({tag, "_run_idle"}, 64'(bus_now()), 64'(IDLE_BUS));
    chk({tag, "_run_busy"}, 64'(busy), 64'd1);
    if (stop_at >= 0) begin
      step();
      chk({tag, "_pend_stop"}, 64'(bus_now()), 64'(wr(4'd1, 16'h0008)));
      step();
      chk({tag, "_pend_idle"}, 64'(bus_now()), 64'(IDLE_BUS));
      chk({tag, "_pend_busy"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic service(input string tag);
    bus_if.irq = 1'b1;
    step();
    bus_if.irq = 1'b0;
    model_count = model_count + 16'd1;
    chk({tag, "_clr"}, 64'(bus_now()), 64'(wr(4'd0, 16'h0000)));
    chk({tag, "_tick"}, 64'(tick), 64'd1);
    chk({tag, "_count"}, 64'(tick_count), 64'(model_count));
    step();
    chk({tag, "_wait"}, 64'(bus_now()), 64'(IDLE_BUS));
    chk({tag, "_tick0"}, 64'(tick), 64'd0);
    step();
  endtask

  task automatic do_stop(input string tag);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk({tag, "_stopwr"}, 64'(bus_now()), 64'(wr(4'd1, 16'h0008)));
    step();
    chk({tag, "_idle"}, 64'(bus_now()), 64'(IDLE_BUS));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_snap(input string tag, input logic [31:0] value);
    slave_counter = value;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
    chk({tag, "_wr6"}, 64'(bus_now()), 64'(wr(4'd6, 16'h0000)));
    step();
    chk({tag, "_rd6"}, 64'(bus_now()), 64'(rd(4'd6)));
    step();
    chk({tag, "_rd7"}, 64'(bus_now()), 64'(rd(4'd7)));
    step();
    chk({tag, "_cap"}, 64'(bus_now()), 64'(IDLE_BUS));
    chk({tag, "_valid_early"}, 64'(snap_valid), 64'd0);
    model_snap = value;
    step();
    chk({tag, "_valid"}, 64'(snap_valid), 64'd1);
    chk({tag, "_value"}, 64'(snap_value), 64'(model_snap));
    step();
    chk({tag, "_valid_pulse"}, 64'(snap_valid), 64'd0);
`else
    chk({tag, "_ignored"}, 64'(bus_now()), 64'(IDLE_BUS));
    chk({tag, "_valid0"}, 64'(snap_valid), 64'd0);
    chk({tag, "_value0"}, 64'(snap_value), 64'(model_snap));
    step();
`endif
  endtask

  initial begin
    reset_n       = 1'b0;
    cfg_period    = 32'h0;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    snap_req      = 1'b0;
    bus_if.irq    = 1'b0;
    slave_counter = 32'h0;
    model_count   = 16'h0000;
    model_snap    = 32'h0;
    repeat (3) step();
    chk("rst_bus", 64'(bus_now()), 64'(IDLE_BUS));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_count", 64'(tick_count), 64'd0);
    chk("rst_snap", 64'({snap_valid, snap_value}), 64'd0);
    reset_n = 1'b1;
    step();

    cfg_stop = 1'b1;
    snap_req = 1'b1;
    step();
    cfg_stop = 1'b0;
    snap_req = 1'b0;
    chk("idle_ignore_bus", 64'(bus_now()), 64'(IDLE_BUS));
    chk("idle_ignore_busy", 64'(busy), 64'd0);
    step();

    do_start("start", 32'h0001_86A0, -1, -1);
    step();
    chk("run_hold", 64'(bus_now()), 64'(IDLE_BUS));
    service("svc1");

    force dut.tick_count = 16'hFFFF;
    #1;
    release dut.tick_count;
    model_count = 16'hFFFF;
    service("wrap");

    do_snap("snap", 32'h0012_3456);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: service("rand_svc");
        1: begin
          repeat ($urandom_range(1, 4)) begin
            step();
            chk("rand_idle", 64'(bus_now()), 64'(IDLE_BUS));
          end
        end
        default: do_snap("rand_snap", $urandom);
      endcase
    end

    cfg_start  = 1'b1;
    cfg_period = $urandom;
    step();
    cfg_start  = 1'b0;
    chk("start_in_run_bus", 64'(bus_now()), 64'(IDLE_BUS));
    chk("start_in_run_busy", 64'(busy), 64'd1);

    bus_if.irq = 1'b1;
    cfg_stop   = 1'b1;
    step();
    bus_if.irq = 1'b0;
    cfg_stop   = 1'b0;
    chk("irqstop_wr", 64'(bus_now()), 64'(wr(4'd1, 16'h0008)));
    chk("irqstop_tick", 64'(tick), 64'd0);
    chk("irqstop_count", 64'(tick_count), 64'(model_count));
    step();
    chk("irqstop_idle", 64'(bus_now()), 64'(IDLE_BUS));
    chk("irqstop_busy", 64'(busy), 64'd0);
    chk("irqstop_tick2", 64'(tick), 64'd0);

    do_start("stop_p1", $urandom, 1, -1);
    step();
    do_start("restart", $urandom, -1, 0);
    service("svc_after_restart");
    do_stop("stop_run");

    for (int r = 0; r < 3; r++) begin
      do_start("rand_start", $urandom, -1, -1);
      repeat ($urandom_range(1, 3)) service("rand_start_svc");
      do_stop("rand_stop");
    end

    cfg_period = 32'hCAFE_F00D;
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    model_count = 16'h0000;
    model_snap  = 32'h0;
    chk("midrst_bus", 64'(bus_now()), 64'(IDLE_BUS));
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_count", 64'(tick_count), 64'(model_count));
    chk("midrst_snap", 64'({snap_valid, snap_value}), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", 64'(bus_now()), 64'(IDLE_BUS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
